// File: rtl/broadsync_pkg.sv
// Shared definitions for the BroadSync timecode serializer and its future receiver:
// state encoding, CRC polynomial and the frame length calculation.
package broadsync_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    SHIFT = 2'd2
  } bs_state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Start bit + lock bit + accuracy + seconds + nanoseconds + optional CRC-8.
  function automatic int frame_bits(input int acc_w, input int s_w, input int ns_w,
                                    input int crc_en);
    return 2 + acc_w + s_w + ns_w + ((crc_en != 0) ? 8 : 0);
  endfunction

endpackage

// File: rtl/broadsync_crc8.sv
// Serial CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR), one bit per enable,
// bits presented in transmit order.
module broadsync_crc8
  import broadsync_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q;

  // Shift one bit into the CRC; clear restarts the checksum for a new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= '0;
    end else if (clear) begin
      crc_q <= '0;
    end else if (en) begin
      crc_q <= {crc_q[6:0], 1'b0} ^ (CRC8_POLY & {8{crc_q[7] ^ din}});
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/broadsync_tc_serializer.sv
// BroadSync timecode serializer: free-running bit clock, one frame per accepted
// frame_en, data launched on bit clock falling edges so it is stable at each rise.
module broadsync_tc_serializer
  import broadsync_pkg::*;
#(
  parameter int S_WIDTH    = 48,
  parameter int NS_WIDTH   = 30,
  parameter int ACC_WIDTH  = 8,
  parameter int BITCLK_DIV = 4,
  parameter int CRC_EN     = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic                        ptp_clk,
  input  logic                        ptp_reset,
  input  logic                        frame_en,
  input  logic                        lock_value_in,
  input  logic [ACC_WIDTH-1:0]        clk_accuracy_in,
  input  logic [S_WIDTH+NS_WIDTH-1:0] time_value_in,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        frame_drop,
  output logic                        bitclock_out,
  output logic                        heartbeat_out,
  output logic                        timecode_out
);

  localparam int FRAME_BITS = frame_bits(ACC_WIDTH, S_WIDTH, NS_WIDTH, CRC_EN);
  localparam int DATA_BITS  = 1 + ACC_WIDTH + S_WIDTH + NS_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int DIV_W      = $clog2(BITCLK_DIV);

  // Bit clock divider.
  logic [DIV_W-1:0] div_q;
  logic             bclk_q;
  logic             div_wrap;
  logic             fall_tick;

  // Frame state.
  bs_state_e          state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [7:0]         crc_sh_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               hb_q;
  logic               tc_q;

  // Combinational helpers.
  logic [ACC_WIDTH-1:0] acc_ord;
  logic [S_WIDTH-1:0]   s_ord;
  logic [NS_WIDTH-1:0]  ns_ord;
  logic [DATA_BITS-1:0] tx_vec;
  logic [7:0]           crc_val;
  logic [7:0]           crc_bits;
  logic                 accept;
  logic                 data_phase;
  logic                 crc_en;

  assign div_wrap  = (div_q == DIV_W'(BITCLK_DIV - 1));
  assign fall_tick = div_wrap & bclk_q;

  // The frame_done cycle is still part of the frame, so requests there are refused too.
  assign accept     = frame_en & ~busy_q & ~done_q;
  assign frame_drop = frame_en & (busy_q | done_q);

  // Free-running bit clock: toggle every BITCLK_DIV cycles from reset release.
  always_ff @(posedge ptp_clk or posedge ptp_reset) begin
    if (ptp_reset) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else if (div_wrap) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values,
      // so div_q and bclk_q update together regardless of statement order.
      div_q  <= '0;
      bclk_q <= ~bclk_q;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Arrange each field in transmit bit order; the field order itself never changes.
  always_comb begin
    // NOTE: every output of this block gets a value before any condition, so no latch.
    acc_ord = clk_accuracy_in;
    s_ord   = time_value_in[S_WIDTH+NS_WIDTH-1:NS_WIDTH];
    ns_ord  = time_value_in[NS_WIDTH-1:0];
    if (MSB_FIRST == 0) begin
      for (int i = 0; i < ACC_WIDTH; i++) acc_ord[i] = clk_accuracy_in[ACC_WIDTH-1-i];
      for (int i = 0; i < S_WIDTH; i++)   s_ord[i]   = time_value_in[NS_WIDTH+S_WIDTH-1-i];
      for (int i = 0; i < NS_WIDTH; i++)  ns_ord[i]  = time_value_in[NS_WIDTH-1-i];
    end
  end

  assign tx_vec = {lock_value_in, acc_ord, s_ord, ns_ord};

  // The first CRC bit comes straight from the checksum, later ones from the shift copy.
  always_comb begin
    crc_bits = crc_sh_q;
    if (bit_cnt_q == CNT_W'(DATA_BITS + 1)) crc_bits = crc_val;
  end

  assign data_phase = (bit_cnt_q <= CNT_W'(DATA_BITS)) && (bit_cnt_q != CNT_W'(0));
  assign crc_en     = (state_q == SHIFT) && fall_tick && data_phase;

  broadsync_crc8 u_crc (
    .clk   (ptp_clk),
    .reset (ptp_reset),
    .clear (accept),
    .en    (crc_en),
    .din   (shift_q[DATA_BITS-1]),
    .crc   (crc_val)
  );

  // Frame FSM: capture on accept, start on the next bit clock fall, one bit per fall.
  always_ff @(posedge ptp_clk or posedge ptp_reset) begin
    if (ptp_reset) begin
      // NOTE: the shadow/shift register is reset as well; it is small, and a known
      // value after reset keeps an aborted frame from leaking into the next one.
      state_q   <= IDLE;
      shift_q   <= '0;
      crc_sh_q  <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hb_q      <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q <= tx_vec;
            busy_q  <= 1'b1;
            state_q <= PEND;
          end
        end
        PEND: begin
          if (fall_tick) begin
            state_q   <= SHIFT;
            tc_q      <= 1'b1;
            hb_q      <= 1'b1;
            bit_cnt_q <= CNT_W'(1);
          end
        end
        SHIFT: begin
          if (fall_tick) begin
            hb_q <= 1'b0;
            if (bit_cnt_q == CNT_W'(FRAME_BITS)) begin
              state_q   <= IDLE;
              tc_q      <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (data_phase) begin
                tc_q    <= shift_q[DATA_BITS-1];
                shift_q <= {shift_q[DATA_BITS-2:0], 1'b0};
              end else begin
                tc_q     <= crc_bits[7];
                crc_sh_q <= {crc_bits[6:0], 1'b0};
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign bitclock_out  = bclk_q;
  assign heartbeat_out = hb_q;
  assign timecode_out  = tc_q;

endmodule
